// File: rtl/gate_response_checker.sv
// Response checker for the two-input gate block: compares sampled gate outputs against the golden truth table.
// Optional build macro GATE_CHK_STOP_ON_ERR_EN ends a run on the first mismatching vector.
module gate_response_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and_g,
  input  logic             or_g,
  input  logic             not_a_g,
  input  logic             xor_g,
  input  logic             xnor_g,
  input  logic             nand_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [5:0]       fail_mask,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [3:0]       coverage
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;
`ifdef GATE_CHK_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  state_t           state_q;
  logic             busy_q, done_q, pass_q, ffv_valid_q;
  logic [CNT_W-1:0] vec_q, err_q;
  logic [5:0]       mask_q;
  logic [1:0]       ffv_q;
  logic [3:0]       cov_q;

  logic [5:0]       exp_v, act_v, mism;
  logic [CNT_W-1:0] vec_d, err_d;
  logic [3:0]       cov_d;
  logic             any_mism, run_end;

  // Bit order {nand,xnor,xor,not_a,or,and} is shared by expected, actual and fail_mask.
  always_comb begin
    exp_v    = {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
    act_v    = {nand_g, xnor_g, xor_g, not_a_g, or_g, and_g};
    mism     = exp_v ^ act_v;
    any_mism = |mism;
    vec_d    = vec_q + 1'b1;
    err_d    = (any_mism && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
    cov_d    = cov_q;
    cov_d[{a, b}] = 1'b1;
    run_end  = (vec_d == NUM_V) || (STOP_ON_ERR && any_mism);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      vec_q       <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      ffv_q       <= '0;
      ffv_valid_q <= 1'b0;
      cov_q       <= '0;
    end else if (start) begin
      // start wins in every state; any same-cycle strobe is discarded.
      state_q     <= RUN;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      vec_q       <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      ffv_q       <= '0;
      ffv_valid_q <= 1'b0;
      cov_q       <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (in_valid) begin
            vec_q  <= vec_d;
            err_q  <= err_d;
            cov_q  <= cov_d;
            mask_q <= mask_q | mism;
            if (any_mism && !ffv_valid_q) begin
              ffv_q       <= {a, b};
              ffv_valid_q <= 1'b1;
            end
            if (run_end) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0) && (cov_d == 4'b1111);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_count        = vec_q;
  assign err_count        = err_q;
  assign fail_mask        = mask_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffv_valid_q;
  assign coverage         = cov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: drives a golden or faulty gate model and checks the result registers.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0;
  logic       and_g = 1'b0, or_g = 1'b0, not_a_g = 1'b1, xor_g = 1'b0, xnor_g = 1'b1, nand_g = 1'b1;
  logic       busy, done, pass, first_fail_valid;
  logic [7:0] vec_count, err_count;
  logic [5:0] fail_mask;
  logic [1:0] first_fail_vec;
  logic [3:0] coverage;

  int checks = 0;
  int errors = 0;
  logic xor_stuck = 1'b0;

  gate_response_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .and_g(and_g), .or_g(or_g), .not_a_g(not_a_g), .xor_g(xor_g), .xnor_g(xnor_g), .nand_g(nand_g),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .fail_mask(fail_mask), .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid),
    .coverage(coverage)
  );

  always #5 clk = ~clk;

  logic [31:0] st;
  assign st = {busy, done, pass, vec_count, err_count, fail_mask, first_fail_vec, first_fail_valid, coverage};

  function automatic logic [31:0] mk(input logic bz, input logic dn, input logic ps, input logic [7:0] vc,
                                     input logic [7:0] ec, input logic [5:0] fm, input logic [1:0] fv,
                                     input logic fvv, input logic [3:0] cv);
    return {bz, dn, ps, vc, ec, fm, fv, fvv, cv};
  endfunction

  task automatic drive_gates(input logic [1:0] ab);
    a       = ab[1];
    b       = ab[0];
    and_g   = ab[1] & ab[0];
    or_g    = ab[1] | ab[0];
    not_a_g = ~ab[1];
    xor_g   = xor_stuck ? 1'b0 : (ab[1] ^ ab[0]);
    xnor_g  = ~(ab[1] ^ ab[0]);
    nand_g  = ~(ab[1] & ab[0]);
  endtask

  // Called at a negedge; returns at a negedge with start low.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One strobe per vector, with gap idle cycles after each one.
  task automatic sweep(input logic [7:0] vecs, input int gap);
    for (int i = 3; i >= 0; i--) begin
      drive_gates(vecs[2*i +: 2]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (st !== 32'h0) begin errors++; $display("FAIL reset_state got=%h exp=%h", st, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_gates(2'b10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (st !== 32'h0) begin errors++; $display("FAIL idle_strobe_ignored got=%h exp=%h", st, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_full_sweep();
    pulse_start();
    checks++;
    if (st !== mk(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL start_busy got=%h exp=%h", st, mk(1,0,0,0,0,0,0,0,0)); end
    drive_gates(2'b00);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (st !== mk(1,0,0,1,0,0,0,0,4'b0001)) begin errors++; $display("FAIL first_strobe got=%h exp=%h", st, mk(1,0,0,1,0,0,0,0,4'b0001)); end
    pulse_start();
    sweep(8'b00_01_10_11, 0);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL full_sweep got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    $display("test_full_sweep done");
  endtask

  task automatic test_partial_coverage();
    pulse_start();
    sweep(8'b00_01_01_11, 0);
    checks++;
    if (st !== mk(0,1,0,4,0,0,0,0,4'b1011)) begin errors++; $display("FAIL partial_cov got=%h exp=%h", st, mk(0,1,0,4,0,0,0,0,4'b1011)); end
    $display("test_partial_coverage done");
  endtask

  // xor stuck at 0 fails vectors 01 and 10; xor is bit 3 of the mask.
  task automatic test_xor_stuck();
    logic [31:0] exp_st;
`ifdef GATE_CHK_STOP_ON_ERR_EN
    exp_st = mk(0,1,0,2,1,6'b001000,2'b01,1,4'b0011);
`else
    exp_st = mk(0,1,0,4,2,6'b001000,2'b01,1,4'b1111);
`endif
    xor_stuck = 1'b1;
    pulse_start();
    sweep(8'b00_01_10_11, 0);
    xor_stuck = 1'b0;
    checks++;
    if (st !== exp_st) begin errors++; $display("FAIL xor_stuck got=%h exp=%h", st, exp_st); end
    $display("test_xor_stuck done");
  endtask

  task automatic test_restart_from_done();
    pulse_start();
    checks++;
    if (st !== mk(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL restart_clear got=%h exp=%h", st, mk(1,0,0,0,0,0,0,0,0)); end
    sweep(8'b00_01_10_11, 0);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL restart_sweep got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    $display("test_restart_from_done done");
  endtask

  task automatic test_reset_midrun();
    xor_stuck = 1'b1;
    pulse_start();
    drive_gates(2'b01);
    in_valid = 1'b1;
    @(negedge clk);
    drive_gates(2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    xor_stuck = 1'b0;
    checks++;
    if (st !== mk(1,0,0,2,1,6'b001000,2'b01,1,4'b1010)) begin errors++; $display("FAIL pre_reset got=%h exp=%h", st, mk(1,0,0,2,1,6'b001000,2'b01,1,4'b1010)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 32'h0) begin errors++; $display("FAIL async_reset got=%h exp=%h", st, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    sweep(8'b11_10_01_00, 0);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL post_reset_sweep got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    $display("test_reset_midrun done");
  endtask

  task automatic test_gaps_and_done_strobe();
    pulse_start();
    sweep(8'b00_01_10_11, 3);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL gap_sweep got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    xor_stuck = 1'b1;
    drive_gates(2'b01);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    xor_stuck = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL done_frozen got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    $display("test_gaps_and_done_strobe done");
  endtask

  task automatic test_start_with_valid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_gates(2'b11);
    in_valid = 1'b1;
    pulse_start();
    in_valid = 1'b0;
    checks++;
    if (st !== mk(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL idle_start_valid got=%h exp=%h", st, mk(1,0,0,0,0,0,0,0,0)); end
    xor_stuck = 1'b1;
    drive_gates(2'b10);
    in_valid = 1'b1;
    @(negedge clk);
    xor_stuck = 1'b0;
    drive_gates(2'b00);
    pulse_start();
    in_valid = 1'b0;
    checks++;
    if (st !== mk(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL run_restart got=%h exp=%h", st, mk(1,0,0,0,0,0,0,0,0)); end
    sweep(8'b00_01_10_11, 0);
    checks++;
    if (st !== mk(0,1,1,4,0,0,0,0,4'b1111)) begin errors++; $display("FAIL run_restart_sweep got=%h exp=%h", st, mk(0,1,1,4,0,0,0,0,4'b1111)); end
    $display("test_start_with_valid done");
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_partial_coverage();
    test_xor_stuck();
    test_restart_from_done();
    test_reset_midrun();
    test_gaps_and_done_strobe();
    test_start_with_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
